// File: rtl/block_writer.sv
// Tile-map write-back engine: queues tile updates from the hit logic and commits them to the
// shared tile-map RAM port whenever the renderer leaves it free; also keeps the score and bump window.
module block_writer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int ADDR_W      = 10,
    parameter int SCORE_W     = 16,
    parameter int POINT_VALUE = 100,
    parameter int LOCK_CYCLES = 2000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [5:0]         req_block,
    input  logic               req_point,
    output logic               req_ready,
    input  logic               map_busy,
    output logic               map_we,
    output logic [ADDR_W-1:0]  map_addr,
    output logic [5:0]         map_wdata,
    output logic [SCORE_W-1:0] score,
    output logic               bump_active,
    output logic [ADDR_W-1:0]  bump_addr,
    output logic               overflow_err
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(LOCK_CYCLES + 1);
    localparam int ENTRY_W = ADDR_W + 7;
    localparam int SUM_W   = SCORE_W + 1;

    typedef enum logic {IDLE, WRITE} state_e;

    state_e state_q, state_d;

    logic [ENTRY_W-1:0] fifo_q [FIFO_DEPTH];
    logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]  last_addr_q, last_addr_d;
    logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic [CNT_W-1:0]   bump_cnt_q, bump_cnt_d;
    logic [ADDR_W-1:0]  map_addr_q, map_addr_d;
    logic [5:0]         map_wdata_q, map_wdata_d;
    logic               pend_point_q, pend_point_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [ADDR_W-1:0]  bump_addr_q, bump_addr_d;
    logic               overflow_q, overflow_d;

    logic               fifo_empty;
    logic               fifo_full;
    logic               is_dup;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;
    logic [SUM_W-1:0]   score_sum;

    // Full when the pointers wrap to the same slot on different laps.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign is_dup     = (req_addr == last_addr_q) && (lock_cnt_q != '0);
    assign push       = req_valid && !fifo_full && !is_dup;
    assign pop        = (state_q == IDLE) && !fifo_empty;
    assign head       = fifo_q[rd_ptr_q[PTR_W-1:0]];
    assign score_sum  = {1'b0, score_q} + SUM_W'(POINT_VALUE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = WRITE;
            WRITE:   if (!map_busy)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        map_we = (state_q == WRITE) && !map_busy;
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        last_addr_d  = last_addr_q;
        lock_cnt_d   = lock_cnt_q;
        bump_cnt_d   = bump_cnt_q;
        map_addr_d   = map_addr_q;
        map_wdata_d  = map_wdata_q;
        pend_point_d = pend_point_q;
        score_d      = score_q;
        bump_addr_d  = bump_addr_q;
        overflow_d   = overflow_q;

        if (push) begin
            wr_ptr_d    = wr_ptr_q + 1'b1;
            last_addr_d = req_addr;
            lock_cnt_d  = CNT_W'(LOCK_CYCLES);
        end else if (lock_cnt_q != '0) begin
            lock_cnt_d  = lock_cnt_q - CNT_W'(1);
        end

        if (req_valid && fifo_full && !is_dup) begin
            overflow_d = 1'b1;
        end

        if (pop) begin
            rd_ptr_d     = rd_ptr_q + 1'b1;
            map_addr_d   = head[ENTRY_W-1:7];
            map_wdata_d  = head[6:1];
            pend_point_d = head[0];
        end

        // A commit reloads the bump window; otherwise it just runs down.
        if (map_we) begin
            bump_addr_d = map_addr_q;
            bump_cnt_d  = CNT_W'(LOCK_CYCLES);
            if (pend_point_q) begin
                score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
            end
        end else if (bump_cnt_q != '0) begin
            bump_cnt_d = bump_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            last_addr_q  <= '0;
            lock_cnt_q   <= '0;
            bump_cnt_q   <= '0;
            map_addr_q   <= '0;
            map_wdata_q  <= '0;
            pend_point_q <= 1'b0;
            score_q      <= '0;
            bump_addr_q  <= '0;
            overflow_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            last_addr_q  <= last_addr_d;
            lock_cnt_q   <= lock_cnt_d;
            bump_cnt_q   <= bump_cnt_d;
            map_addr_q   <= map_addr_d;
            map_wdata_q  <= map_wdata_d;
            pend_point_q <= pend_point_d;
            score_q      <= score_d;
            bump_addr_q  <= bump_addr_d;
            overflow_q   <= overflow_d;
        end
    end

    // Queue storage needs no reset: the pointers decide which slots are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q[PTR_W-1:0]] <= {req_addr, req_block, req_point};
        end
    end

    assign req_ready    = !fifo_full;
    assign map_addr     = map_addr_q;
    assign map_wdata    = map_wdata_q;
    assign score        = score_q;
    assign bump_active  = (bump_cnt_q != '0);
    assign bump_addr    = bump_addr_q;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_block_writer.sv
// Randomized and directed bench for block_writer, checked every cycle against a
// queue/timestamp reference model of the write-back behaviour.
module tb_block_writer;

    localparam int DEPTH  = 4;
    localparam int AW     = 10;
    localparam int SW     = 8;
    localparam int PV     = 100;
    localparam int LOCK   = 10;
    localparam int SCMAX  = 255;

    logic          clk;
    logic          rst_n;
    logic          reqValid;
    logic [AW-1:0] reqAddr;
    logic [5:0]    reqBlock;
    logic          reqPoint;
    logic          reqReady;
    logic          mapBusy;
    logic          mapWe;
    logic [AW-1:0] mapAddr;
    logic [5:0]    mapWdata;
    logic [SW-1:0] score;
    logic          bumpActive;
    logic [AW-1:0] bumpAddr;
    logic          overflowErr;

    block_writer #(
        .FIFO_DEPTH (DEPTH),
        .ADDR_W     (AW),
        .SCORE_W    (SW),
        .POINT_VALUE(PV),
        .LOCK_CYCLES(LOCK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (reqValid),
        .req_addr    (reqAddr),
        .req_block   (reqBlock),
        .req_point   (reqPoint),
        .req_ready   (reqReady),
        .map_busy    (mapBusy),
        .map_we      (mapWe),
        .map_addr    (mapAddr),
        .map_wdata   (mapWdata),
        .score       (score),
        .bump_active (bumpActive),
        .bump_addr   (bumpAddr),
        .overflow_err(overflowErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [5:0]    block;
        logic          point;
    } entry_t;

    // Reference model: a queue plus the edge numbers at which lock/bump windows expire.
    entry_t        mq[$];
    int            t;
    logic          mInWrite;
    logic [AW-1:0] mPendAddr;
    logic [5:0]    mPendBlock;
    logic          mPendPoint;
    logic [AW-1:0] mLastAddr;
    int            mLockUntil;
    int            mBumpUntil;
    logic [AW-1:0] mBumpAddr;
    int            mScore;
    logic          mOverflow;

    int testCount = 0;
    int failCount = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h (edge %0d, time %0t)", tag, observed, expected, t, $time);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        t          = 0;
        mInWrite   = 1'b0;
        mPendAddr  = '0;
        mPendBlock = '0;
        mPendPoint = 1'b0;
        mLastAddr  = '0;
        mLockUntil = 0;
        mBumpUntil = 0;
        mBumpAddr  = '0;
        mScore     = 0;
        mOverflow  = 1'b0;
    endtask

    task automatic modelStep();
        bit     full;
        bit     dup;
        entry_t e;
        t++;
        full = (mq.size() == DEPTH);
        dup  = (reqAddr == mLastAddr) && (t <= mLockUntil);
        if (mInWrite && !mapBusy) begin
            if (mPendPoint) mScore = (mScore + PV > SCMAX) ? SCMAX : mScore + PV;
            mBumpAddr  = mPendAddr;
            mBumpUntil = t + LOCK;
            mInWrite   = 1'b0;
        end else if (!mInWrite && mq.size() > 0) begin
            e          = mq.pop_front();
            mPendAddr  = e.addr;
            mPendBlock = e.block;
            mPendPoint = e.point;
            mInWrite   = 1'b1;
        end
        if (reqValid && !dup) begin
            if (!full) begin
                e.addr  = reqAddr;
                e.block = reqBlock;
                e.point = reqPoint;
                mq.push_back(e);
                mLastAddr  = reqAddr;
                mLockUntil = t + LOCK;
            end else begin
                mOverflow = 1'b1;
            end
        end
    endtask

    task automatic checkAll();
        checkOutput("req_ready",    32'(reqReady),    32'(mq.size() < DEPTH));
        checkOutput("map_we",       32'(mapWe),       32'(mInWrite && !mapBusy));
        checkOutput("map_addr",     32'(mapAddr),     32'(mPendAddr));
        checkOutput("map_wdata",    32'(mapWdata),    32'(mPendBlock));
        checkOutput("score",        32'(score),       32'(mScore));
        checkOutput("bump_active",  32'(bumpActive),  32'(t < mBumpUntil));
        checkOutput("bump_addr",    32'(bumpAddr),    32'(mBumpAddr));
        checkOutput("overflow_err", 32'(overflowErr), 32'(mOverflow));
    endtask

    // Called at a falling edge; holds the inputs for the given number of rising edges.
    task automatic applyStimulus(input logic valid, input logic [AW-1:0] addr, input logic [5:0] block,
                                 input logic point, input logic busy, input int cycles);
        reqValid = valid;
        reqAddr  = addr;
        reqBlock = block;
        reqPoint = point;
        mapBusy  = busy;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            modelStep();
            #1 checkAll();
            @(negedge clk);
        end
    endtask

    task automatic doReset(input int holdCycles);
        reqValid = 1'b0;
        mapBusy  = 1'b0;
        rst_n    = 1'b0;
        #1;
        modelReset();
        checkAll();
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk);
            #1 checkAll();
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        reqValid = 1'b0;
        reqAddr  = '0;
        reqBlock = '0;
        reqPoint = 1'b0;
        mapBusy  = 1'b0;
        modelReset();
        @(negedge clk);
        doReset(2);

        $display("[TB] single request held valid");
        applyStimulus(1'b1, 10'h05A, 6'd34, 1'b1, 1'b0, 50);
        applyStimulus(1'b0, 10'h000, 6'd0, 1'b0, 1'b0, 15);

        $display("[TB] renderer contention");
        applyStimulus(1'b1, 10'h100, 6'd5, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 10'h000, 6'd0, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 10'h000, 6'd0, 1'b0, 1'b1, 7);
        applyStimulus(1'b0, 10'h000, 6'd0, 1'b0, 1'b0, 5);

        $display("[TB] burst overflow");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 10'(10'h200 + i), 6'(i + 1), 1'b1, 1'b1, 1);
        end
        applyStimulus(1'b0, 10'h000, 6'd0, 1'b0, 1'b1, 3);
        applyStimulus(1'b0, 10'h000, 6'd0, 1'b0, 1'b0, 15);

        $display("[TB] duplicate window and point-free request");
        applyStimulus(1'b1, 10'h010, 6'd7, 1'b1, 1'b0, 1);
        applyStimulus(1'b0, 10'h000, 6'd0, 1'b0, 1'b0, 4);
        applyStimulus(1'b1, 10'h010, 6'd8, 1'b1, 1'b0, 1);
        applyStimulus(1'b0, 10'h000, 6'd0, 1'b0, 1'b0, 14);
        applyStimulus(1'b1, 10'h010, 6'd9, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 10'h000, 6'd0, 1'b0, 1'b0, 12);

        $display("[TB] randomized traffic");
        doReset(1);
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(1'($urandom_range(99) < 60), 10'(10'h030 + $urandom_range(7)),
                          6'($urandom_range(63)), 1'($urandom_range(1)),
                          1'($urandom_range(99) < 30), 1);
        end

        $display("[TB] reset mid-operation");
        applyStimulus(1'b0, 10'h000, 6'd0, 1'b0, 1'b0, 12);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 10'(10'h300 + i), 6'(i + 10), 1'b1, 1'b1, 1);
        end
        doReset(2);
        applyStimulus(1'b0, 10'h000, 6'd0, 1'b0, 1'b0, 20);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
